// File: rtl/cpu_pkg.sv
// Shared types and widths for the program-counter / status-flag stage.
package cpu_pkg;

  localparam int PC_W  = 10;
  localparam int LUT_W = 5;

  typedef logic [PC_W-1:0] pc_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } pc_state_t;

endpackage

// File: rtl/branch_lut.sv
// Branch/jump target table: maps a small instruction-encoded index to a full PC.
// Entries are regenerated by the assembler flow; unlisted indices resolve to address 0.
module branch_lut
  import cpu_pkg::*;
(
  input  logic [LUT_W-1:0] lut_idx,
  output pc_t              target
);

  always_comb begin
    target = '0;
    case (lut_idx)
      5'd1:    target = pc_t'(10);
      5'd2:    target = pc_t'(100);
      5'd3:    target = pc_t'(200);
      5'd4:    target = pc_t'(511);
      5'd5:    target = pc_t'(1023);
      5'd6:    target = pc_t'(64);
      5'd7:    target = pc_t'(300);
      5'd8:    target = pc_t'(37);
      default: target = '0;
    endcase
  end

endmodule

// File: rtl/pc_flag_unit.sv
// PC sequencer and compare/carry flag registers beside the 8-bit ALU, with the
// Start/Done handshake (IDLE -> RUN -> DONE).
module pc_flag_unit
  import cpu_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             halt,
  input  logic             jump_en,
  input  logic             branch_en,
  input  logic [LUT_W-1:0] lut_idx,
  input  logic             cmp_en,
  input  logic             branch_in,
  input  logic             carry_we,
  input  logic             carry_clr,
  input  logic             carry_in,
  output logic [PC_W-1:0]  prog_ctr,
  output logic             flag_q,
  output logic             carry_q,
  output logic             running,
  output logic             done
);

  pc_state_t state, state_next;
  pc_t       pc_next, target;
  logic      flag_next, carry_next;

  branch_lut u_lut (
    .lut_idx (lut_idx),
    .target  (target)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      prog_ctr <= '0;
      flag_q   <= 1'b0;
      carry_q  <= 1'b0;
      running  <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      prog_ctr <= pc_next;
      flag_q   <= flag_next;
      carry_q  <= carry_next;
      running  <= (state_next == RUN);
      done     <= (state_next == DONE);
    end
  end

  // Branch tests the flag as registered, so a same-cycle compare only affects later branches.
  always_comb begin
    state_next = state;
    pc_next    = prog_ctr;
    flag_next  = flag_q;
    carry_next = carry_q;
    if (Start) begin
      state_next = IDLE;
      pc_next    = '0;
    end else begin
      case (state)
        IDLE: state_next = RUN;
        RUN: begin
          if (cmp_en)
            flag_next = branch_in;
          if (carry_clr)
            carry_next = 1'b0;
          else if (carry_we)
            carry_next = carry_in;
          if (halt)
            state_next = DONE;
          else if (jump_en)
            pc_next = target;
          else if (branch_en && flag_q)
            pc_next = target;
          else
            pc_next = prog_ctr + 1'b1;
        end
        DONE: state_next = DONE;
        default: begin
          state_next = IDLE;
          pc_next    = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_flag_unit.sv
// Self-checking bench for pc_flag_unit: directed scenarios followed by random
// decoder traffic, all compared against a cycle-level behavioural model.
module tb_pc_flag_unit;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic       Clk = 1'b0;
  logic       Reset, Start, halt, jump_en, branch_en;
  logic [4:0] lut_idx;
  logic       cmp_en, branch_in, carry_we, carry_clr, carry_in;
  logic [9:0] prog_ctr;
  logic       flag_q, carry_q, running, done;

  int nChecks = 0;
  int nPass   = 0;
  int mMode   = M_IDLE;
  int mPc     = 0;
  int mFlag   = 0;
  int mCarry  = 0;
  int tbl[int];

  pc_flag_unit dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .halt      (halt),
    .jump_en   (jump_en),
    .branch_en (branch_en),
    .lut_idx   (lut_idx),
    .cmp_en    (cmp_en),
    .branch_in (branch_in),
    .carry_we  (carry_we),
    .carry_clr (carry_clr),
    .carry_in  (carry_in),
    .prog_ctr  (prog_ctr),
    .flag_q    (flag_q),
    .carry_q   (carry_q),
    .running   (running),
    .done      (done)
  );

  always #5 Clk = ~Clk;

  function automatic int lookup(input int idx);
    return tbl.exists(idx) ? tbl[idx] : 0;
  endfunction

  task automatic expectEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // One clock edge of the reference: what the stage should hold after this edge.
  task automatic modelStep();
    int oldFlag;
    oldFlag = mFlag;
    if (Reset) begin
      mMode = M_IDLE; mPc = 0; mFlag = 0; mCarry = 0;
    end else if (Start) begin
      mMode = M_IDLE; mPc = 0;
    end else if (mMode == M_IDLE) begin
      mMode = M_RUN;
    end else if (mMode == M_RUN) begin
      if (cmp_en) mFlag = int'(branch_in);
      if (carry_clr) mCarry = 0;
      else if (carry_we) mCarry = int'(carry_in);
      if (halt) mMode = M_DONE;
      else if (jump_en) mPc = lookup(int'(lut_idx));
      else if (branch_en && oldFlag == 1) mPc = lookup(int'(lut_idx));
      else mPc = (mPc + 1) % 1024;
    end
  endtask

  task automatic checkOutput(input string tag);
    expectEq({tag, "_pc"},      32'(prog_ctr), 32'(mPc));
    expectEq({tag, "_flag"},    32'(flag_q),   32'(mFlag));
    expectEq({tag, "_carry"},   32'(carry_q),  32'(mCarry));
    expectEq({tag, "_running"}, 32'(running),  32'(mMode == M_RUN));
    expectEq({tag, "_done"},    32'(done),     32'(mMode == M_DONE));
  endtask

  task automatic applyStimulus(input string tag);
    @(posedge Clk);
    modelStep();
    #1;
    checkOutput(tag);
  endtask

  task automatic clearInputs();
    Reset = 0; Start = 0; halt = 0; jump_en = 0; branch_en = 0; lut_idx = '0;
    cmp_en = 0; branch_in = 0; carry_we = 0; carry_clr = 0; carry_in = 0;
  endtask

  task automatic restartRun(input string tag);
    clearInputs();
    Start = 1;
    applyStimulus({tag, "_start"});
    Start = 0;
    applyStimulus({tag, "_run0"});
  endtask

  initial begin
    tbl[1] = 10;  tbl[2] = 100; tbl[3] = 200; tbl[4] = 511;
    tbl[5] = 1023; tbl[6] = 64; tbl[7] = 300; tbl[8] = 37;

    clearInputs();
    Reset = 1; Start = 1;
    applyStimulus("rst_a");
    applyStimulus("rst_b");
    expectEq("rst_pc", 32'(prog_ctr), 32'd0);

    // Count from 0 through 5, then halt and hold.
    Reset = 0;
    applyStimulus("t2_start");
    Start = 0;
    applyStimulus("t2_run0");
    expectEq("t2_pc0", 32'(prog_ctr), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus("t2_inc");
      expectEq("t2_pc_seq", 32'(prog_ctr), 32'(i));
    end
    halt = 1;
    applyStimulus("t2_halt");
    halt = 0; jump_en = 1; lut_idx = 5'd3; cmp_en = 1; branch_in = 1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus("t2_hold");
      expectEq("t2_hold_pc", 32'(prog_ctr), 32'd5);
      expectEq("t2_hold_done", 32'(done), 32'd1);
    end

    // Reset while running at PC 37 with both flags set.
    restartRun("t1");
    cmp_en = 1; branch_in = 1; carry_we = 1; carry_in = 1;
    applyStimulus("t1_flags");
    cmp_en = 0; carry_we = 0;
    for (int i = 0; i < 100 && mPc != 37; i++) applyStimulus("t1_walk");
    expectEq("t1_at37", 32'(prog_ctr), 32'd37);
    Reset = 1;
    applyStimulus("t1_reset");
    expectEq("t1_pc", 32'(prog_ctr), 32'd0);
    expectEq("t1_flag", 32'(flag_q), 32'd0);
    expectEq("t1_carry", 32'(carry_q), 32'd0);
    expectEq("t1_done", 32'(done), 32'd0);

    // Branch taken and not taken on the compare result.
    restartRun("t3");
    cmp_en = 1; branch_in = 1;
    applyStimulus("t3_cmp1");
    cmp_en = 0; branch_en = 1; lut_idx = 5'd3;
    applyStimulus("t3_br_taken");
    expectEq("t3_taken_pc", 32'(prog_ctr), 32'd200);
    branch_en = 0; cmp_en = 1; branch_in = 0;
    applyStimulus("t3_cmp0");
    cmp_en = 0; branch_en = 1;
    applyStimulus("t3_br_not");
    expectEq("t3_not_pc", 32'(prog_ctr), 32'd202);

    // Same-cycle compare and branch sees the old flag.
    cmp_en = 1; branch_in = 1; branch_en = 1;
    applyStimulus("t4_same");
    expectEq("t4_pc", 32'(prog_ctr), 32'd203);
    expectEq("t4_flag", 32'(flag_q), 32'd1);

    // Halt outranks jump and branch; jump wins otherwise.
    clearInputs();
    halt = 1; jump_en = 1; branch_en = 1; lut_idx = 5'd2;
    applyStimulus("t5_halt");
    expectEq("t5_halt_pc", 32'(prog_ctr), 32'd203);
    expectEq("t5_halt_done", 32'(done), 32'd1);
    restartRun("t5");
    jump_en = 1; branch_en = 1; lut_idx = 5'd2;
    applyStimulus("t5_jump");
    expectEq("t5_jump_pc", 32'(prog_ctr), 32'd100);

    // Carry write/clear priority and PC wrap.
    clearInputs();
    carry_we = 1; carry_in = 1;
    applyStimulus("t6_cwe");
    expectEq("t6_carry1", 32'(carry_q), 32'd1);
    carry_clr = 1;
    applyStimulus("t6_cclr");
    expectEq("t6_carry0", 32'(carry_q), 32'd0);
    clearInputs();
    jump_en = 1; lut_idx = 5'd5;
    applyStimulus("t6_jmax");
    expectEq("t6_pcmax", 32'(prog_ctr), 32'd1023);
    clearInputs();
    applyStimulus("t6_wrap");
    expectEq("t6_wrap_pc", 32'(prog_ctr), 32'd0);
    expectEq("t6_wrap_done", 32'(done), 32'd0);
    lut_idx = 5'd20; jump_en = 1;
    applyStimulus("t6_unknown_idx");
    expectEq("t6_unknown_pc", 32'(prog_ctr), 32'd0);

    // Random decoder traffic.
    for (int i = 0; i < 400; i++) begin
      Reset     = ($urandom % 60) == 0;
      Start     = ($urandom % 25) == 0;
      halt      = ($urandom % 20) == 0;
      jump_en   = ($urandom % 6) == 0;
      branch_en = ($urandom % 3) == 0;
      lut_idx   = 5'($urandom_range(0, 31));
      cmp_en    = ($urandom % 3) == 0;
      branch_in = 1'($urandom);
      carry_we  = ($urandom % 3) == 0;
      carry_clr = ($urandom % 5) == 0;
      carry_in  = 1'($urandom);
      applyStimulus("rand");
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
